fp_int_accumulator: RTL and testbench

Downstream consumer of the bit-serial FP16×INT multiplier. Captures each finished product (sign, 5-bit exponent, 14-bit 4.10 mantissa), aligns it by exponent into a wide two's-complement fixed-point accumulator, and sums a programmable number of products. It then normalizes the sum serially into an IEEE-754 FP32 result and presents it with a valid/ready handshake. A one-entry skid buffer absorbs a product that arrives while a result is still being normalized or held.

---
 rtl/fp_int_accumulator_if.sv | 28 ++
 rtl/fp_int_accumulator.sv | 198 +++++++++++++++++++
 tb/tb_fp_int_accumulator.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_int_accumulator_if.sv
// Product-in / FP32-result bundle between the FP16xINT multiplier, the
// accumulator and the result consumer.
interface fp_int_accumulator_if #(
    parameter int LEN_WIDTH = 8
);
    logic                 set;
    logic [LEN_WIDTH-1:0] len;
    logic                 start_acc;
    logic                 sign_in;
    logic [4:0]           exp_in;
    logic [13:0]          mantissa_in;
    logic [31:0]          result;
    logic                 result_valid;
    logic                 result_ready;
    logic                 overflow;
    logic                 overrun;
    logic                 busy;

    modport master (
        output set, len, start_acc, sign_in, exp_in, mantissa_in, result_ready,
        input  result, result_valid, overflow, overrun, busy
    );

    modport slave (
        input  set, len, start_acc, sign_in, exp_in, mantissa_in, result_ready,
        output result, result_valid, overflow, overrun, busy
    );
endinterface

// File: rtl/fp_int_accumulator.sv
// Sums groups of exponent-aligned FP16xINT products in a saturating fixed-point
// accumulator and serially normalizes each sum to FP32. FP_INT_ACC_ROUND_EN adds RNE rounding.
module fp_int_accumulator #(
    parameter int ACC_WIDTH = 48,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fp_int_accumulator_if.slave  bus
);
    localparam int SH_W     = $clog2(ACC_WIDTH + 1);
    localparam int EXP_BASE = ACC_WIDTH + 101;

`ifdef FP_INT_ACC_ROUND_EN
    typedef enum logic [2:0] {ST_ACC, ST_ABS, ST_NORM, ST_RND, ST_OUT} state_t;
`else
    typedef enum logic [2:0] {ST_ACC, ST_ABS, ST_NORM, ST_OUT} state_t;
`endif

    state_t                 state_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [ACC_WIDTH-1:0]   mag_q;
    logic [SH_W-1:0]        sh_q;
    logic                   res_sign_q;
    logic [31:0]            result_q;
    logic                   valid_q;
    logic                   overflow_q;
    logic                   overrun_q;
    logic                   busy_q;
    logic                   skid_full_q;
    logic                   skid_sign_q;
    logic [4:0]             skid_exp_q;
    logic [13:0]            skid_mant_q;

    logic                   prod_sign_w;
    logic [4:0]             prod_exp_w;
    logic [13:0]            prod_mant_w;
    logic                   in_out_w;
    logic                   handshake_w;
    logic                   take_w;
    logic                   last_w;
    logic [ACC_WIDTH-1:0]   acc_base_w;
    logic [LEN_WIDTH-1:0]   cnt_base_w;
    logic [ACC_WIDTH-1:0]   term_w;
    logic [ACC_WIDTH:0]     sum_w;
    logic                   sum_ovf_w;
    logic [ACC_WIDTH-1:0]   sum_sat_w;
    logic [ACC_WIDTH-1:0]   mag_abs_w;
    logic [7:0]             exp_w;

    // A buffered product always goes ahead of whatever arrives on the input.
    assign prod_sign_w = skid_full_q ? skid_sign_q : bus.sign_in;
    assign prod_exp_w  = skid_full_q ? skid_exp_q  : bus.exp_in;
    assign prod_mant_w = skid_full_q ? skid_mant_q : bus.mantissa_in;

    assign in_out_w    = (state_q == ST_OUT);
    assign handshake_w = in_out_w & valid_q & bus.result_ready;
    assign take_w      = ((state_q == ST_ACC) | handshake_w) & (skid_full_q | bus.start_acc);

    // On the handshake edge the accepted product starts a fresh group.
    assign acc_base_w = in_out_w ? '0 : acc_q;
    assign cnt_base_w = in_out_w ? '0 : cnt_q;
    assign last_w     = (({1'b0, cnt_base_w} + {{LEN_WIDTH{1'b0}}, 1'b1}) == {1'b0, len_q});

    assign term_w    = {{(ACC_WIDTH-14){1'b0}}, prod_mant_w} << prod_exp_w;
    assign sum_w     = prod_sign_w ? ({acc_base_w[ACC_WIDTH-1], acc_base_w} - {1'b0, term_w})
                                   : ({acc_base_w[ACC_WIDTH-1], acc_base_w} + {1'b0, term_w});
    assign sum_ovf_w = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
    assign sum_sat_w = !sum_ovf_w       ? sum_w[ACC_WIDTH-1:0] :
                       sum_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};

    assign mag_abs_w = acc_q[ACC_WIDTH-1] ? ('0 - acc_q) : acc_q;
    assign exp_w     = EXP_BASE[7:0] - 8'(sh_q);

`ifdef FP_INT_ACC_ROUND_EN
    logic guard_w;
    logic sticky_w;
    logic round_up_w;
    assign guard_w    = mag_q[ACC_WIDTH-25];
    assign sticky_w   = |mag_q[ACC_WIDTH-26:0];
    assign round_up_w = guard_w & (sticky_w | result_q[0]);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_ACC;
            len_q       <= {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            cnt_q       <= '0;
            acc_q       <= '0;
            mag_q       <= '0;
            sh_q        <= '0;
            res_sign_q  <= 1'b0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            skid_full_q <= 1'b0;
            skid_sign_q <= 1'b0;
            skid_exp_q  <= '0;
            skid_mant_q <= '0;
        end else if (bus.set) begin
            len_q       <= (bus.len == '0) ? {{(LEN_WIDTH-1){1'b0}}, 1'b1} : bus.len;
            cnt_q       <= '0;
            acc_q       <= '0;
            skid_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            overrun_q   <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_ACC;
        end else begin
            case (state_q)
                ST_ABS: begin
                    res_sign_q <= acc_q[ACC_WIDTH-1];
                    mag_q      <= mag_abs_w;
                    sh_q       <= '0;
                    if (acc_q == '0) begin
                        result_q <= '0;
                        state_q  <= ST_OUT;
                    end else begin
                        state_q  <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (mag_q[ACC_WIDTH-1]) begin
                        result_q <= {res_sign_q, exp_w, mag_q[ACC_WIDTH-2:ACC_WIDTH-24]};
`ifdef FP_INT_ACC_ROUND_EN
                        state_q  <= ST_RND;
`else
                        state_q  <= ST_OUT;
`endif
                    end else begin
                        mag_q <= mag_q << 1;
                        sh_q  <= sh_q + {{(SH_W-1){1'b0}}, 1'b1};
                    end
                end
`ifdef FP_INT_ACC_ROUND_EN
                // A fraction carry ripples into the exponent field and clears the fraction.
                ST_RND: begin
                    result_q[30:0] <= result_q[30:0] + {30'd0, round_up_w};
                    state_q        <= ST_OUT;
                end
`endif
                ST_OUT: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (bus.result_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_ACC;
                    end
                end
                default: ;
            endcase

            if (take_w) begin
                if (skid_full_q) begin
                    skid_full_q <= bus.start_acc;
                    skid_sign_q <= bus.sign_in;
                    skid_exp_q  <= bus.exp_in;
                    skid_mant_q <= bus.mantissa_in;
                end
                acc_q <= sum_sat_w;
                if (sum_ovf_w) overflow_q <= 1'b1;
                if (last_w) begin
                    cnt_q   <= '0;
                    state_q <= ST_ABS;
                    busy_q  <= 1'b1;
                end else begin
                    cnt_q   <= cnt_base_w + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                    state_q <= ST_ACC;
                    busy_q  <= 1'b0;
                end
            end else if (bus.start_acc && (state_q != ST_ACC)) begin
                if (!skid_full_q) begin
                    skid_full_q <= 1'b1;
                    skid_sign_q <= bus.sign_in;
                    skid_exp_q  <= bus.exp_in;
                    skid_mant_q <= bus.mantissa_in;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.overrun      = overrun_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_fp_int_accumulator.sv
// Scoreboard bench for fp_int_accumulator: a reference model queues the expected
// FP32 result, overflow flag and latency of every group; outputs are checked on result_valid.
module tb_fp_int_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fp_int_accumulator_if #(.LEN_WIDTH(8)) bus ();

    fp_int_accumulator #(.ACC_WIDTH(48), .LEN_WIDTH(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } exp_t;

    localparam longint MAXP = (longint'(1) << 47) - 1;
    localparam longint MINN = -(longint'(1) << 47);

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint m_acc   = 0;
    int     m_cnt   = 0;
    int     m_len   = 1;
    bit     m_ovf   = 1'b0;

    function automatic logic [31:0] model_fp32(input longint s, output int lat);
        logic [63:0] mb;
        logic [24:0] frac;
        int          p;
        int          e;
`ifdef FP_INT_ACC_ROUND_EN
        bit          g;
        bit          st;
`endif
        lat = 2;
        if (s == 0) return 32'h0;
        mb = (s < 0) ? 64'(-s) : 64'(s);
        p = 0;
        for (int i = 0; i < 64; i++) if (mb[i]) p = i;
        e = 102 + p;
        if (p >= 23) frac = 25'(mb >> (p - 23));
        else         frac = 25'(mb << (23 - p));
        lat = 3 + (47 - p);
`ifdef FP_INT_ACC_ROUND_EN
        lat++;
        if (p >= 24) begin
            g  = mb[p-24];
            st = (mb & ((64'd1 << (p - 24)) - 64'd1)) != 64'd0;
            if (g && (st || frac[0])) frac = frac + 25'd1;
            if (frac[24]) begin
                frac = frac >> 1;
                e++;
            end
        end
`endif
        return {(s < 0), 8'(e), frac[22:0]};
    endfunction

    task automatic model_accept(input bit s, input logic [4:0] e, input logic [13:0] m);
        longint term;
        exp_t   ex;
        int     lat;
        term  = longint'(m) << e;
        m_acc = s ? (m_acc - term) : (m_acc + term);
        if (m_acc > MAXP) begin m_acc = MAXP; m_ovf = 1'b1; end
        else if (m_acc < MINN) begin m_acc = MINN; m_ovf = 1'b1; end
        m_cnt++;
        if (m_cnt == m_len) begin
            ex.res = model_fp32(m_acc, lat);
            ex.ovf = m_ovf;
            ex.lat = lat;
            sb.push_back(ex);
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic set_len(input logic [7:0] l);
        @(negedge clk);
        bus.set = 1'b1;
        bus.len = l;
        @(negedge clk);
        bus.set = 1'b0;
        m_len = (l == 8'd0) ? 1 : int'(l);
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Holds start_acc high across the next rising edge; counted=0 marks a product expected to be dropped.
    task automatic send(input bit s, input logic [4:0] e, input logic [13:0] m, input bit counted);
        @(negedge clk);
        bus.start_acc   = 1'b1;
        bus.sign_in     = s;
        bus.exp_in      = e;
        bus.mantissa_in = m;
        if (counted) model_accept(s, e, m);
    endtask

    task automatic idle;
        @(negedge clk);
        bus.start_acc = 1'b0;
    endtask

    task automatic handshake;
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.result_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic get_result(output exp_t ex, output logic [31:0] r, output logic o,
                              output int cyc, output bit to);
        wait_valid(cyc, to);
        r = bus.result;
        o = bus.overflow;
        if (sb.size() > 0) ex = sb.pop_front();
        else begin ex.res = 'x; ex.ovf = 1'bx; ex.lat = -1; end
        $display("[TB] result=%h overflow=%b latency=%0d expected=%h/%b/%0d",
                 r, o, cyc, ex.res, ex.ovf, ex.lat);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_tests += 5;
        if (bus.result !== 32'h0)    begin n_fail++; $display("FAIL reset_result got %h want 00000000", bus.result); end
        if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.result_valid); end
        if (bus.overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        if (bus.overrun !== 1'b0)    begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
        if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        exp_t ex; logic [31:0] r; logic o; int cyc; bit to;
        send(1'b0, 5'd15, 14'h400, 1'b1);
        idle();
        get_result(ex, r, o, cyc, to);
        n_tests += 4;
        if (to || cyc !== ex.lat) begin n_fail++; $display("FAIL single_latency got %0d want %0d", cyc, ex.lat); end
        if (r !== ex.res)         begin n_fail++; $display("FAIL single_result got %h want %h", r, ex.res); end
        if (o !== ex.ovf)         begin n_fail++; $display("FAIL single_overflow got %b want %b", o, ex.ovf); end
        if (bus.busy !== 1'b1)    begin n_fail++; $display("FAIL single_busy got %b want 1", bus.busy); end
        handshake();
        n_tests++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL single_release got valid=%b busy=%b want 0/0", bus.result_valid, bus.busy);
        end
    endtask

    task automatic test_zero_sum;
        exp_t ex; logic [31:0] r; logic o; int cyc; bit to;
        set_len(8'd2);
        send(1'b0, 5'd15, 14'h400, 1'b1);
        send(1'b1, 5'd15, 14'h400, 1'b1);
        idle();
        get_result(ex, r, o, cyc, to);
        n_tests += 2;
        if (to || cyc !== ex.lat) begin n_fail++; $display("FAIL zero_latency got %0d want %0d", cyc, ex.lat); end
        if (r !== ex.res)         begin n_fail++; $display("FAIL zero_result got %h want %h", r, ex.res); end
        handshake();
    endtask

    task automatic test_three;
        exp_t ex; logic [31:0] r; logic o; int cyc; bit to;
        set_len(8'd3);
        for (int k = 0; k < 3; k++) send(1'b0, 5'd15, 14'h400, 1'b1);
        idle();
        get_result(ex, r, o, cyc, to);
        n_tests += 2;
        if (to || cyc !== ex.lat) begin n_fail++; $display("FAIL three_latency got %0d want %0d", cyc, ex.lat); end
        if (r !== ex.res)         begin n_fail++; $display("FAIL three_result got %h want %h", r, ex.res); end
        handshake();
    endtask

    task automatic test_negative;
        exp_t ex; logic [31:0] r; logic o; int cyc; bit to;
        set_len(8'd0);
        send(1'b1, 5'd16, 14'h600, 1'b1);
        idle();
        get_result(ex, r, o, cyc, to);
        n_tests += 2;
        if (to || cyc !== ex.lat) begin n_fail++; $display("FAIL negative_latency got %0d want %0d", cyc, ex.lat); end
        if (r !== ex.res)         begin n_fail++; $display("FAIL negative_result got %h want %h", r, ex.res); end
        handshake();
    endtask

    task automatic test_saturation;
        exp_t ex; logic [31:0] r; logic o; int cyc; bit to;
        set_len(8'd255);
        for (int k = 0; k < 255; k++) send(1'b0, 5'd31, 14'h3FFF, 1'b1);
        idle();
        get_result(ex, r, o, cyc, to);
        n_tests += 3;
        if (to || cyc !== ex.lat) begin n_fail++; $display("FAIL sat_latency got %0d want %0d", cyc, ex.lat); end
        if (r !== ex.res)         begin n_fail++; $display("FAIL sat_result got %h want %h", r, ex.res); end
        if (o !== ex.ovf)         begin n_fail++; $display("FAIL sat_overflow got %b want %b", o, ex.ovf); end
        handshake();
    endtask

    task automatic test_skid;
        exp_t ex; logic [31:0] r; logic o; int cyc; bit to;
        set_len(8'd1);
        n_tests++;
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL skid_set_clears_overflow got %b want 0", bus.overflow); end
        send(1'b0, 5'd15, 14'h400, 1'b1);
        idle();
        get_result(ex, r, o, cyc, to);
        n_tests += 2;
        if (to)           begin n_fail++; $display("FAIL skid_first_timeout got %0d cycles", cyc); end
        if (r !== ex.res) begin n_fail++; $display("FAIL skid_first_result got %h want %h", r, ex.res); end
        send(1'b0, 5'd16, 14'h400, 1'b1);
        send(1'b0, 5'd17, 14'h400, 1'b0);
        idle();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (bus.result !== ex.res || bus.result_valid !== 1'b1) begin
                n_fail++; $display("FAIL skid_hold got %h valid=%b want %h valid=1", bus.result, bus.result_valid, ex.res);
            end
        end
        n_tests++;
        if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL skid_overrun got %b want 1", bus.overrun); end
        handshake();
        get_result(ex, r, o, cyc, to);
        n_tests += 3;
        if (to || cyc !== ex.lat) begin n_fail++; $display("FAIL skid_second_latency got %0d want %0d", cyc, ex.lat); end
        if (r !== ex.res)         begin n_fail++; $display("FAIL skid_second_result got %h want %h", r, ex.res); end
        if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL skid_overrun_sticky got %b want 1", bus.overrun); end
        handshake();
    endtask

    task automatic test_back_to_back;
        exp_t ex; logic [31:0] r; logic o; int cyc; bit to;
        set_len(8'd4);
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 4; k++)
                send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 20)), 14'($urandom), 1'b1);
            idle();
            get_result(ex, r, o, cyc, to);
            n_tests += 3;
            if (to || cyc !== ex.lat) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", cyc, ex.lat); end
            if (r !== ex.res)         begin n_fail++; $display("FAIL b2b_result got %h want %h", r, ex.res); end
            if (o !== ex.ovf)         begin n_fail++; $display("FAIL b2b_overflow got %b want %b", o, ex.ovf); end
            handshake();
        end
    endtask

    task automatic test_reset_in_norm;
        exp_t ex; logic [31:0] r; logic o; int cyc; bit to;
        set_len(8'd1);
        send(1'b1, 5'd14, 14'h2A5, 1'b1);
        idle();
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL norm_busy_before_reset got %b want 1", bus.busy); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.result, bus.result_valid, bus.overflow, bus.overrun, bus.busy} !== 36'h0) begin
            n_fail++; $display("FAIL norm_reset got result=%h valid=%b ovf=%b ovr=%b busy=%b want all 0",
                               bus.result, bus.result_valid, bus.overflow, bus.overrun, bus.busy);
        end
        sb.delete();
        m_acc = 0; m_cnt = 0; m_len = 1; m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_len(8'd1);
        send(1'b0, 5'd15, 14'h400, 1'b1);
        idle();
        get_result(ex, r, o, cyc, to);
        n_tests += 2;
        if (to || cyc !== ex.lat) begin n_fail++; $display("FAIL after_reset_latency got %0d want %0d", cyc, ex.lat); end
        if (r !== ex.res)         begin n_fail++; $display("FAIL after_reset_result got %h want %h", r, ex.res); end
        handshake();
    endtask

    initial begin
        bus.set          = 1'b0;
        bus.len          = 8'd0;
        bus.start_acc    = 1'b0;
        bus.sign_in      = 1'b0;
        bus.exp_in       = 5'd0;
        bus.mantissa_in  = 14'd0;
        bus.result_ready = 1'b0;
        test_reset();
        test_single();
        test_zero_sum();
        test_three();
        test_negative();
        test_saturation();
        test_skid();
        test_back_to_back();
        test_reset_in_norm();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
